// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
//
// One valid/ready payload link between two pipeline stages.
//
// Signals:
//   valid  producer has a payload on data this cycle
//   ready  consumer can take the payload this cycle
//   data   DATA_W-bit packed payload
//
// Modports:
//   master  producer side (drives valid/data, observes ready)
//   slave   consumer side (observes valid/data, drives ready)
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W = 75
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Registered one-cycle pipeline hop with a valid/ready handshake, synchronous
// flush and a two-entry skid buffer. Full throughput is sustained while the
// downstream stage keeps ready high; back-pressure is absorbed by the skid
// register so that in_ready never depends combinationally on out_ready.
//
// Parameters:
//   DATA_W     payload width in bits (packed EX/MEM bundle is 75 bits)
//   RESET_VAL  value held by the payload registers after reset
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous kill of every held entry
//   up         slave side of the upstream link  (in_valid / in_ready / in_data)
//   dn         master side of the downstream link (out_valid / out_ready / out_data)
//   occupancy  number of live entries: 0, 1 or 2
//
// Build option:
//   PIPE_STAGE_BUBBLE_ZERO_EN  when defined, out_data is forced to RESET_VAL
//                              whenever out_valid is low (zeroed bubbles).
//                              When undefined, payload registers only load on
//                              accept or skid transfer and out_data must be
//                              qualified by out_valid.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                 DATA_W    = 75,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    pipe_stage_reg_if.slave       up,
    pipe_stage_reg_if.master      dn,
    output logic [1:0]            occupancy
);

    // State encoding equals the live-entry count, so occupancy is the state.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              accept;
    logic              emit;

    assign accept = up.valid & in_ready_q;
    assign emit   = out_valid_q & dn.ready;

    // Next-state and payload steering. Flush overrides every transition; an
    // entry accepted or emitted in the flush cycle is simply consumed.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
`endif
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        main_d  = up.data;
                    end
                end
                S_ONE: begin
                    if (accept && emit) begin
                        main_d  = up.data;
                    end else if (accept) begin
                        // Downstream stalled: park the new payload behind main.
                        state_d = S_FULL;
                        skid_d  = up.data;
                    end else if (emit) begin
                        state_d = S_EMPTY;
`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
                        main_d  = RESET_VAL;
`endif
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so only the drain path exists.
                    if (emit) begin
                        state_d = S_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs are registered from the next state so that neither
    // out_ready nor flush reaches in_ready combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != S_FULL);
            out_valid_q <= (state_d != S_EMPTY);
            main_q      <= main_d;
            skid_q      <= skid_d;
        end
    end

    assign up.ready  = in_ready_q;
    assign dn.valid  = out_valid_q;
    assign dn.data   = main_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Drives a 75-bit and a 1-bit instance of pipe_stage_reg with the same
// handshake stimulus. The driver keeps a two-slot FIFO model of the stage and
// pushes every payload it expects to be taken into a queue; an independent
// monitor pops that queue whenever the 75-bit instance emits.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int W = 75;

    logic clk;
    logic reset;
    logic flush;
    logic [1:0] occ75;
    logic [1:0] occ1;

    pipe_stage_reg_if #(.DATA_W(W)) up75 ();
    pipe_stage_reg_if #(.DATA_W(W)) dn75 ();
    pipe_stage_reg_if #(.DATA_W(1)) up1 ();
    pipe_stage_reg_if #(.DATA_W(1)) dn1 ();

    pipe_stage_reg #(.DATA_W(W)) dut75 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .up        (up75.slave),
        .dn        (dn75.master),
        .occupancy (occ75)
    );

    pipe_stage_reg #(.DATA_W(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .up        (up1.slave),
        .dn        (dn1.master),
        .occupancy (occ1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           mcnt       = 0;
    int           cur_cnt    = 0;
    bit           flush_pend = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus plus the model update for that cycle.
    task automatic step(input logic iv, input logic ordy, input logic fl, input logic [W-1:0] d);
        bit acc;
        bit emi;
        @(posedge clk);
        #1;
        if (flush_pend) begin
            exp_q.delete();
            flush_pend = 1'b0;
        end
        up75.valid = iv;
        up75.data  = d;
        up1.valid  = iv;
        up1.data   = d[0];
        dn75.ready = ordy;
        dn1.ready  = ordy;
        flush      = fl;
        cur_cnt    = mcnt;
        acc = iv && (mcnt < 2);
        emi = ordy && (mcnt > 0);
        if (fl) begin
            mcnt       = 0;
            flush_pend = 1'b1;
        end else begin
            if (acc) exp_q.push_back(d);
            mcnt = mcnt + int'(acc) - int'(emi);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid75"}, W'(dn75.valid), W'(0));
        chk({tag, "_ready75"}, W'(up75.ready), W'(1));
        chk({tag, "_occ75"},   W'(occ75),      W'(0));
        chk({tag, "_data75"},  dn75.data,      W'(0));
        chk({tag, "_valid1"},  W'(dn1.valid),  W'(0));
        chk({tag, "_occ1"},    W'(occ1),       W'(0));
        chk({tag, "_data1"},   W'(dn1.data),   W'(0));
    endtask

    // Reset pulsed between edges while the stage is full.
    task automatic async_reset_midstream();
        @(posedge clk);
        #2;
        chk("pre_reset_occ", W'(occ75), W'(2));
        up75.valid = 1'b0; up1.valid = 1'b0;
        dn75.ready = 1'b0; dn1.ready = 1'b0;
        flush = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        flush_pend = 1'b0;
        mcnt    = 0;
        cur_cnt = 0;
    endtask

    // Monitor: compares registered outputs against the model every cycle and
    // pops the expected payload on each downstream handshake.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid75", W'(dn75.valid), W'(cur_cnt > 0));
            chk("in_ready75",  W'(up75.ready), W'(cur_cnt < 2));
            chk("occupancy75", W'(occ75),      W'(cur_cnt));
            chk("out_valid1",  W'(dn1.valid),  W'(cur_cnt > 0));
            chk("in_ready1",   W'(up1.ready),  W'(cur_cnt < 2));
            chk("occupancy1",  W'(occ1),       W'(cur_cnt));
            chk("ready_when_full", W'(up75.ready && (occ75 == 2'd2)), W'(0));
`ifdef PIPE_STAGE_BUBBLE_ZERO_EN
            if (cur_cnt == 0) begin
                chk("bubble_zero75", dn75.data,    W'(0));
                chk("bubble_zero1",  W'(dn1.data), W'(0));
            end
`endif
            if (dn75.valid && dn75.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_emit got %0h expected nothing at %0t", dn75.data, $time);
                end else begin
                    chk("out_data75", dn75.data,    exp_q[0]);
                    chk("out_data1",  W'(dn1.data), W'(exp_q[0][0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [W-1:0] d;
        reset      = 1'b1;
        flush      = 1'b0;
        up75.valid = 1'b0; up75.data = '0;
        up1.valid  = 1'b0; up1.data  = 1'b0;
        dn75.ready = 1'b0; dn1.ready = 1'b0;
        #12;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset then stream 1, 2, 3 at full throughput.
        step(1'b1, 1'b1, 1'b0, W'(1));
        step(1'b1, 1'b1, 1'b0, W'(2));
        step(1'b1, 1'b1, 1'b0, W'(3));
        step(1'b0, 1'b1, 1'b0, W'(0));
        step(1'b0, 1'b1, 1'b0, W'(0));

        // Stall into the skid register, offer a third word while full, drain.
        step(1'b1, 1'b0, 1'b0, W'('hA));
        step(1'b1, 1'b0, 1'b0, W'('hB));
        step(1'b1, 1'b0, 1'b0, W'('hD));
        step(1'b0, 1'b0, 1'b0, W'(0));
        step(1'b0, 1'b1, 1'b0, W'(0));
        step(1'b0, 1'b1, 1'b0, W'(0));
        step(1'b0, 1'b1, 1'b0, W'(0));

        // Flush while full with 0xC offered.
        step(1'b1, 1'b0, 1'b0, W'('h11));
        step(1'b1, 1'b0, 1'b0, W'('h12));
        step(1'b1, 1'b0, 1'b1, W'('hC));
        step(1'b0, 1'b0, 1'b0, W'(0));
        step(1'b0, 1'b1, 1'b0, W'(0));

        // Flush in ONE while a new word is accepted and the head is emitted.
        step(1'b1, 1'b0, 1'b0, W'('h21));
        step(1'b1, 1'b1, 1'b1, W'('h22));
        step(1'b0, 1'b1, 1'b0, W'(0));

        // Asynchronous reset while full.
        step(1'b1, 1'b0, 1'b0, W'('h31));
        step(1'b1, 1'b0, 1'b0, W'('h32));
        step(1'b0, 1'b0, 1'b0, W'(0));
        async_reset_midstream();
        step(1'b1, 1'b1, 1'b0, W'('h41));
        step(1'b0, 1'b1, 1'b0, W'(0));

        // Random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            d[31:0]  = $urandom;
            d[63:32] = $urandom;
            d[74:64] = 11'($urandom);
            step(($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < ((i / 1000) % 2 == 0 ? 60 : 90)),
                 ($urandom_range(0, 99) < 3),
                 d);
        end

        // Drain and confirm nothing is left outstanding.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, W'(0));
        @(posedge clk);
        #1;
        if (flush_pend) exp_q.delete();
        chk("drained", W'(exp_q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
